// File: rtl/i2s_ws_pkg.sv
// i2s_ws_pkg: frame-format and FSM state types shared by the word-select generator.
package i2s_ws_pkg;
  typedef enum logic [1:0] {I2S, LJ, DSP_SHORT, DSP_LONG} mode_e;
  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_e;
endpackage

// File: rtl/i2s_ws_gen_tdm_if.sv
// i2s_ws_gen_tdm_if: configuration inputs and frame-timing outputs of the word-select generator.
interface i2s_ws_gen_tdm_if #(
  parameter int BITS_W  = 5,
  parameter int SLOTS_W = 4,
  parameter int SETUP_W = 16
);
  logic               cfg_en_i;
  logic [1:0]         cfg_mode_i;
  logic [BITS_W-1:0]  cfg_num_bits_i;
  logic [SLOTS_W-1:0] cfg_num_slots_i;
  logic [SETUP_W-1:0] cfg_setup_i;
  logic               cfg_ws_pol_i;
  logic               ws_o;
  logic               frame_start_o;
  logic               slot_start_o;
  logic [SLOTS_W-1:0] slot_idx_o;
  logic [BITS_W-1:0]  bit_idx_o;
  logic               active_o;
  modport master (
    input  cfg_en_i, cfg_mode_i, cfg_num_bits_i, cfg_num_slots_i, cfg_setup_i, cfg_ws_pol_i,
    output ws_o, frame_start_o, slot_start_o, slot_idx_o, bit_idx_o, active_o
  );
  modport slave (
    output cfg_en_i, cfg_mode_i, cfg_num_bits_i, cfg_num_slots_i, cfg_setup_i, cfg_ws_pol_i,
    input  ws_o, frame_start_o, slot_start_o, slot_idx_o, bit_idx_o, active_o
  );
endinterface

// File: rtl/i2s_frame_cnt.sv
// i2s_frame_cnt: bit/slot position counter with registered start strobes.
// Also exposes the next position and whether that next position ends the frame.
module i2s_frame_cnt #(
  parameter int BITS_W  = 5,
  parameter int SLOTS_W = 4
) (
  input  logic               sck_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [BITS_W-1:0]  num_bits_i,
  input  logic [SLOTS_W-1:0] num_slots_i,
  output logic [BITS_W-1:0]  bit_idx_o,
  output logic [BITS_W-1:0]  bit_nxt_o,
  output logic [SLOTS_W-1:0] slot_idx_o,
  output logic [SLOTS_W-1:0] slot_nxt_o,
  output logic               frame_start_o,
  output logic               slot_start_o,
  output logic               last_o
);
  localparam int FW = BITS_W + SLOTS_W;
  logic [BITS_W-1:0]  bit_q, bit_d;
  logic [SLOTS_W-1:0] slot_q, slot_d;
  logic [FW-1:0]      pos_q, pos_d, pos_last;
  logic               frame_start_q, frame_start_d, slot_start_q, slot_start_d;
  logic               restart, bit_wrap, frame_wrap;
  // The last index B*S+B+S always fits in FW bits, whereas the length (B+1)*(S+1) may not.
  assign pos_last = FW'(num_bits_i) * FW'(num_slots_i) + FW'(num_bits_i) + FW'(num_slots_i);
  always_comb begin
    restart       = clr_i || !en_i;
    bit_wrap      = bit_q == num_bits_i;
    frame_wrap    = pos_q == pos_last;
    bit_d         = (restart || bit_wrap) ? '0 : bit_q + BITS_W'(1);
    slot_d        = (restart || (bit_wrap && slot_q == num_slots_i)) ? '0 : slot_q + SLOTS_W'(bit_wrap);
    pos_d         = (restart || frame_wrap) ? '0 : pos_q + FW'(1);
    slot_start_d  = en_i && (clr_i || bit_wrap);
    frame_start_d = en_i && (clr_i || frame_wrap);
  end
  always_ff @(posedge sck_i or negedge rstn_i)
    if (!rstn_i) begin
      bit_q         <= '0;
      slot_q        <= '0;
      pos_q         <= '0;
      frame_start_q <= 1'b0;
      slot_start_q  <= 1'b0;
    end else begin
      bit_q         <= bit_d;
      slot_q        <= slot_d;
      pos_q         <= pos_d;
      frame_start_q <= frame_start_d;
      slot_start_q  <= slot_start_d;
    end
  assign bit_idx_o     = bit_q;
  assign slot_idx_o    = slot_q;
  assign bit_nxt_o     = bit_d;
  assign slot_nxt_o    = slot_d;
  assign frame_start_o = frame_start_q;
  assign slot_start_o  = slot_start_q;
  assign last_o        = pos_d == pos_last;
endmodule

// File: rtl/i2s_ws_gen_tdm.sv
// i2s_ws_gen_tdm: I2S / left-justified / DSP word-select and TDM slot timing generator.
// Every output is registered and describes the position entered on the same edge.
module i2s_ws_gen_tdm
  import i2s_ws_pkg::*;
#(
  parameter int BITS_W  = 5,
  parameter int SLOTS_W = 4,
  parameter int SETUP_W = 16
) (
  input logic                 sck_i,
  input logic                 rstn_i,
  i2s_ws_gen_tdm_if.master    bus
);
  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [BITS_W-1:0]  b_q, b_d, bit_nxt;
  logic [SLOTS_W-1:0] s_q, s_d, slot_nxt, slot_ahead;
  logic [SLOTS_W:0]   half;
  logic [SETUP_W-1:0] n_q, n_d, setup_q, setup_d;
  logic               pol_q, pol_d, ws_q, ws_d, active_q, active_d;
  logic               latch, raw_ws, last_nxt;
  // The *_d config values are the ones in force for the position being entered.
  always_comb begin
    latch    = state_q == IDLE && bus.cfg_en_i;
    mode_d   = latch ? mode_e'(bus.cfg_mode_i) : mode_q;
    b_d      = latch ? bus.cfg_num_bits_i : b_q;
    s_d      = latch ? bus.cfg_num_slots_i : s_q;
    n_d      = latch ? bus.cfg_setup_i : n_q;
    pol_d    = latch ? bus.cfg_ws_pol_i : pol_q;
    state_d  = !bus.cfg_en_i ? IDLE :
               state_q == IDLE ? (bus.cfg_setup_i != '0 ? SETUP : RUN) :
               state_q == SETUP ? (setup_q == n_q - SETUP_W'(1) ? RUN : SETUP) : RUN;
    setup_d  = state_q == SETUP ? setup_q + SETUP_W'(1) : '0;
    active_d = state_d == RUN;
  end
  // I2S leads left-justified by one bit, so it needs the slot one step beyond the next position.
  always_comb begin
    half       = ({1'b0, s_d} + (SLOTS_W + 1)'(1)) >> 1;
    slot_ahead = last_nxt ? '0 : slot_nxt + SLOTS_W'(bit_nxt == b_d);
    raw_ws     = mode_d == I2S ? {1'b0, slot_ahead} >= half :
                 mode_d == LJ ? {1'b0, slot_nxt} >= half :
                 mode_d == DSP_SHORT ? (slot_nxt == '0 && bit_nxt == '0) : slot_nxt == '0;
    ws_d       = state_d == RUN ? raw_ws ^ pol_d : state_d == SETUP ? pol_d : bus.cfg_ws_pol_i;
  end
  always_ff @(posedge sck_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q  <= IDLE;
      mode_q   <= I2S;
      b_q      <= '0;
      s_q      <= '0;
      n_q      <= '0;
      pol_q    <= 1'b0;
      setup_q  <= '0;
      ws_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      b_q      <= b_d;
      s_q      <= s_d;
      n_q      <= n_d;
      pol_q    <= pol_d;
      setup_q  <= setup_d;
      ws_q     <= ws_d;
      active_q <= active_d;
    end
  i2s_frame_cnt #(.BITS_W(BITS_W), .SLOTS_W(SLOTS_W)) u_cnt (
    .sck_i         (sck_i),
    .rstn_i        (rstn_i),
    .en_i          (state_d == RUN),
    .clr_i         (state_q != RUN),
    .num_bits_i    (b_d),
    .num_slots_i   (s_d),
    .bit_idx_o     (bus.bit_idx_o),
    .bit_nxt_o     (bit_nxt),
    .slot_idx_o    (bus.slot_idx_o),
    .slot_nxt_o    (slot_nxt),
    .frame_start_o (bus.frame_start_o),
    .slot_start_o  (bus.slot_start_o),
    .last_o        (last_nxt)
  );
  assign bus.ws_o     = ws_q;
  assign bus.active_o = active_q;
endmodule

// File: tb/tb_i2s_ws_gen_tdm.sv
// tb_i2s_ws_gen_tdm: directed stimulus, per-cycle comparison against a frame-arithmetic model,
// plus hand-computed spot checks at frame and slot boundaries.
module tb_i2s_ws_gen_tdm;
  localparam int BW = 5, SW = 4, NW = 16;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int n_cmp = 0, n_bad = 0;
  i2s_ws_gen_tdm_if #(.BITS_W(BW), .SLOTS_W(SW), .SETUP_W(NW)) bus();
  i2s_ws_gen_tdm #(.BITS_W(BW), .SLOTS_W(SW), .SETUP_W(NW)) dut (
    .sck_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, got, want);
    end
  endtask

  // Model: cycles elapsed since the enable was latched, and the config captured then.
  bit m_run = 1'b0, m_pol = 1'b0, m_ipol = 1'b0;
  int m_k = 0, m_mode = 0, m_b = 0, m_s = 0, m_n = 0;
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_run  <= 1'b0;
      m_k    <= 0;
      m_ipol <= 1'b0;
    end else if (!bus.cfg_en_i) begin
      m_run  <= 1'b0;
      m_ipol <= bus.cfg_ws_pol_i;
    end else if (!m_run) begin
      m_run  <= 1'b1;
      m_k    <= 0;
      m_mode <= int'(bus.cfg_mode_i);
      m_b    <= int'(bus.cfg_num_bits_i);
      m_s    <= int'(bus.cfg_num_slots_i);
      m_n    <= int'(bus.cfg_setup_i);
      m_pol  <= bus.cfg_ws_pol_i;
    end else
      m_k <= m_k + 1;

  typedef struct packed {
    logic ws, fs, ss, act;
    logic [31:0] bi, si;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    int len, p, h;
    e = '0;
    if (m_run && m_k >= m_n) begin
      len   = (m_b + 1) * (m_s + 1);
      p     = (m_k - m_n) % len;
      h     = (m_s + 1) / 2;
      e.bi  = p % (m_b + 1);
      e.si  = p / (m_b + 1);
      e.fs  = p == 0;
      e.ss  = e.bi == 0;
      e.act = 1'b1;
      case (m_mode)
        0:       e.ws = ((p + 1) % len) / (m_b + 1) >= h;
        1:       e.ws = int'(e.si) >= h;
        2:       e.ws = p == 0;
        default: e.ws = e.si == 0;
      endcase
      e.ws = e.ws ^ m_pol;
    end else
      e.ws = m_run ? m_pol : m_ipol;
    return e;
  endfunction

  task automatic cmp_all();
    exp_t e;
    e = model_out();
    chk("ws", 32'(bus.ws_o), 32'(e.ws));
    chk("frame_start", 32'(bus.frame_start_o), 32'(e.fs));
    chk("slot_start", 32'(bus.slot_start_o), 32'(e.ss));
    chk("active", 32'(bus.active_o), 32'(e.act));
    chk("bit_idx", 32'(bus.bit_idx_o), e.bi);
    chk("slot_idx", 32'(bus.slot_idx_o), e.si);
  endtask

  always @(negedge clk) cmp_all();

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int mode, input int b, input int s, input int n, input bit pol);
    bus.cfg_en_i = 1'b0;
    cyc(1);
    bus.cfg_mode_i      = 2'(mode);
    bus.cfg_num_bits_i  = BW'(b);
    bus.cfg_num_slots_i = SW'(s);
    bus.cfg_setup_i     = NW'(n);
    bus.cfg_ws_pol_i    = pol;
    bus.cfg_en_i        = 1'b1;
  endtask

  initial begin
    bus.cfg_en_i = 1'b0;
    bus.cfg_mode_i = '0;
    bus.cfg_num_bits_i = '0;
    bus.cfg_num_slots_i = '0;
    bus.cfg_setup_i = '0;
    bus.cfg_ws_pol_i = 1'b0;
    #1 rstn = 1'b0;
    cyc(2);
    chk("rst_ws", 32'(bus.ws_o), 0);
    chk("rst_active", 32'(bus.active_o), 0);
    chk("rst_bit", 32'(bus.bit_idx_o), 0);
    rstn = 1'b1;
    // Left-justified stereo, 16-bit slots; config edits mid-run must be ignored
    start(1, 15, 1, 0, 1'b0);
    cyc(1);
    chk("lj_p0_fs", 32'(bus.frame_start_o), 1);
    chk("lj_p0_ws", 32'(bus.ws_o), 0);
    cyc(15);
    chk("lj_p15_ws", 32'(bus.ws_o), 0);
    chk("lj_p15_bit", 32'(bus.bit_idx_o), 15);
    cyc(1);
    chk("lj_p16_ws", 32'(bus.ws_o), 1);
    chk("lj_p16_slot", 32'(bus.slot_idx_o), 1);
    bus.cfg_num_bits_i = 5'd3;
    bus.cfg_mode_i = 2'd3;
    cyc(16);
    chk("lj_p32_fs", 32'(bus.frame_start_o), 1);
    chk("lj_p32_ws", 32'(bus.ws_o), 0);
    cyc(40);
    // I2S stereo: ws changes one bit ahead of LJ
    start(0, 15, 1, 0, 1'b0);
    cyc(1);
    chk("i2s_p0_ws", 32'(bus.ws_o), 0);
    cyc(14);
    chk("i2s_p14_ws", 32'(bus.ws_o), 0);
    cyc(1);
    chk("i2s_p15_ws", 32'(bus.ws_o), 1);
    cyc(15);
    chk("i2s_p30_ws", 32'(bus.ws_o), 1);
    cyc(1);
    chk("i2s_p31_ws", 32'(bus.ws_o), 0);
    cyc(1);
    chk("i2s_p32_fs", 32'(bus.frame_start_o), 1);
    // DSP short TDM8 with three setup cycles
    start(2, 7, 7, 3, 1'b0);
    cyc(3);
    chk("dsps_setup_active", 32'(bus.active_o), 0);
    chk("dsps_setup_ws", 32'(bus.ws_o), 0);
    cyc(1);
    chk("dsps_p0_active", 32'(bus.active_o), 1);
    chk("dsps_p0_ws", 32'(bus.ws_o), 1);
    cyc(1);
    chk("dsps_p1_ws", 32'(bus.ws_o), 0);
    cyc(63);
    chk("dsps_p64_ws", 32'(bus.ws_o), 1);
    cyc(20);
    // DSP long, inverted polarity
    start(3, 31, 3, 0, 1'b1);
    cyc(1);
    chk("dspl_p0_ws", 32'(bus.ws_o), 0);
    cyc(31);
    chk("dspl_p31_ws", 32'(bus.ws_o), 0);
    cyc(1);
    chk("dspl_p32_ws", 32'(bus.ws_o), 1);
    cyc(95);
    chk("dspl_p127_ws", 32'(bus.ws_o), 1);
    cyc(1);
    chk("dspl_p128_ws", 32'(bus.ws_o), 0);
    // Disable at slot 1 bit 5 while changing geometry, then re-enable
    start(1, 7, 3, 0, 1'b0);
    cyc(14);
    chk("drop_slot", 32'(bus.slot_idx_o), 1);
    chk("drop_bit", 32'(bus.bit_idx_o), 5);
    bus.cfg_en_i = 1'b0;
    bus.cfg_num_bits_i = 5'd2;
    bus.cfg_num_slots_i = 4'd2;
    cyc(1);
    chk("drop_active", 32'(bus.active_o), 0);
    chk("drop_bit0", 32'(bus.bit_idx_o), 0);
    chk("drop_fs", 32'(bus.frame_start_o), 0);
    bus.cfg_en_i = 1'b1;
    cyc(1);
    chk("reen_fs", 32'(bus.frame_start_o), 1);
    cyc(3);
    chk("reen_slot", 32'(bus.slot_idx_o), 1);
    chk("reen_ss", 32'(bus.slot_start_o), 1);
    chk("reen_ws", 32'(bus.ws_o), 1);
    // One-bit, one-slot I2S frame
    start(0, 0, 0, 0, 1'b0);
    cyc(4);
    chk("b0s0_ss", 32'(bus.slot_start_o), 1);
    chk("b0s0_fs", 32'(bus.frame_start_o), 1);
    chk("b0s0_ws", 32'(bus.ws_o), 1);
    // Single setup cycle, inverted polarity
    start(2, 1, 2, 1, 1'b1);
    cyc(1);
    chk("n1_setup_ws", 32'(bus.ws_o), 1);
    cyc(1);
    chk("n1_p0_ws", 32'(bus.ws_o), 0);
    cyc(12);
    // Largest frame: 32 bits x 16 slots
    start(1, 31, 15, 0, 1'b0);
    cyc(512);
    chk("max_p511_slot", 32'(bus.slot_idx_o), 15);
    chk("max_p511_ws", 32'(bus.ws_o), 1);
    cyc(1);
    chk("max_p512_fs", 32'(bus.frame_start_o), 1);
    // Asynchronous reset mid-frame, then restart through setup
    start(0, 7, 3, 2, 1'b1);
    cyc(12);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ws", 32'(bus.ws_o), 0);
    chk("arst_active", 32'(bus.active_o), 0);
    chk("arst_bit", 32'(bus.bit_idx_o), 0);
    chk("arst_slot", 32'(bus.slot_idx_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(2);
    chk("arst_setup_active", 32'(bus.active_o), 0);
    cyc(1);
    chk("arst_run_fs", 32'(bus.frame_start_o), 1);
    cyc(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2s_ws_gen_tdm.md
I2S_WS_GEN_TDM -- requirements
Module: i2s_ws_gen_tdm

Interface
REQ-001 Parameters SHALL be: BITS_W, 5, width of bits-per-slot field; SLOTS_W, 4, width of slot-count field; SETUP_W, 16, width of setup-time field.
REQ-002 sck_i  in  1  sole clock; all state SHALL update on posedge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 cfg_en_i  in  1  generator enable.
REQ-005 cfg_mode_i  in  2  frame format: 0 I2S, 1 left-justified, 2 DSP short pulse, 3 DSP long pulse.
REQ-006 cfg_num_bits_i  in  BITS_W  bits per slot minus 1 (B).
REQ-007 cfg_num_slots_i  in  SLOTS_W  slots per frame minus 1 (S).
REQ-008 cfg_setup_i  in  SETUP_W  idle sck cycles before first frame (N).
REQ-009 cfg_ws_pol_i  in  1  1 inverts ws_o.
REQ-010 ws_o  out  1  word-select / frame-sync, registered.
REQ-011 frame_start_o  out  1  high for the first bit of every frame.
REQ-012 slot_start_o  out  1  high for the first bit of every slot.
REQ-013 slot_idx_o  out  SLOTS_W  current slot, 0..S.
REQ-014 bit_idx_o  out  BITS_W  current bit within slot, 0..B.
REQ-015 active_o  out  1  high while in RUN.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, RUN; all outputs SHALL be flop outputs.
REQ-017 IDLE with cfg_en_i=1: mode, B, S, N, polarity SHALL be latched on that edge; next state SETUP if N!=0, else RUN.
REQ-018 SETUP SHALL last exactly N cycles, then enter RUN; setup counter SETUP_W bits, cleared on entry.
REQ-019 Latched config SHALL be used until return to IDLE; cfg changes while SETUP/RUN are ignored.
REQ-020 On the RUN entry edge bit_idx_o=0, slot_idx_o=0, frame_start_o=1, slot_start_o=1, active_o=1.
REQ-021 In RUN bit_idx SHALL increment each cycle, wrap B->0 incrementing slot_idx; slot_idx SHALL wrap S->0; frames back-to-back with no gap.
REQ-022 Frame length SHALL be (B+1)*(S+1) cycles, computed in BITS_W+SLOTS_W bits without overflow.
REQ-023 Let H=floor((S+1)/2); left-justified raw ws SHALL be 1 when slot_idx>=H, else 0.
REQ-024 I2S raw ws SHALL equal the left-justified value of the following position (one bit lead), including wrap from last bit of frame to position 0.
REQ-025 DSP short raw ws SHALL be 1 only at slot 0 bit 0; DSP long raw ws SHALL be 1 for all of slot 0.
REQ-026 ws_o SHALL equal raw ws XOR latched polarity in RUN, and cfg_ws_pol_i (inactive level) in IDLE and SETUP.
REQ-027 cfg_en_i=0 sampled in any state SHALL move to IDLE next edge: counters 0, strobes 0, active_o=0, ws_o inactive; no frame completion.
REQ-028 S=0 in I2S/LJ SHALL give H=0, raw ws constantly 1; B=0 SHALL give one-bit slots with slot_start_o high every cycle.

Reset
REQ-029 rstn_i low SHALL force IDLE asynchronously: ws_o=0, frame_start_o=0, slot_start_o=0, slot_idx_o=0, bit_idx_o=0, active_o=0, all latched config and counters 0.
REQ-030 Reset deassertion mid-stream SHALL restart only via a fresh IDLE->SETUP/RUN sequence.

Structure
REQ-031 Package i2s_ws_pkg SHALL hold the frame-mode enum (I2S, LJ, DSP_SHORT, DSP_LONG) and the FSM state enum.
REQ-032 Slot/bit counting SHALL be in sub-module i2s_frame_cnt (inputs B, S, clear, enable; outputs idx, start strobes, last-of-frame).

Verification
REQ-033 LJ, B=15, S=1, N=0, pol=0, enable -> ws_o 0 for 16 cycles, 1 for 16, period 32, frame_start_o every 32.
REQ-034 I2S, B=15, S=1 -> ws_o rises at slot 0 bit 15 and falls at slot 1 bit 15, one cycle ahead of LJ.
REQ-035 DSP short, B=7, S=7 (TDM8), N=3 -> 3 inactive cycles, then 1-cycle ws pulse every 64 cycles.
REQ-036 DSP long, B=31, S=3, pol=1 -> ws_o low for 32 cycles, high 96, repeating.
REQ-037 cfg_en_i dropped at slot 1 bit 5, B/S changed while running -> IDLE next edge, outputs inactive; re-enable restarts at position 0 with new config.
REQ-038 rstn_i asserted mid-frame asynchronously -> all outputs 0 before next sck_i edge.
